// File: rtl/fb_pkg.sv
// fb_pkg: shared frame-buffer geometry, bus widths and arbiter state encoding
package fb_pkg;
    localparam int FB_COLS = 640;
    localparam int FB_ROWS = 480;
    localparam int FB_PIXELS = FB_COLS * FB_ROWS;
    localparam int DEF_ADDR_W = 20;
    localparam int DEF_DATA_W = 16;
    typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE} arb_state_t;
endpackage

// File: rtl/sdram_port_arbiter_if.sv
// sdram_port_arbiter_if: pixel request port plus Avalon-MM master port of the arbiter
interface sdram_port_arbiter_if import fb_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();
    logic Read, Write, Busy, ReadValid, Timeout_Err;
    logic [ADDR_W-1:0] R_Address, W_Address, Avm_Address;
    logic [DATA_W-1:0] BitData, ReadData, Avm_WriteData, Avm_ReadData;
    logic [7:0] Drop_Count;
    logic Avm_Read, Avm_Write, Avm_WaitRequest, Avm_ReadDataValid;
    modport master (
        input Read, R_Address, Write, W_Address, BitData, Avm_WaitRequest, Avm_ReadData, Avm_ReadDataValid,
        output Busy, ReadData, ReadValid, Timeout_Err, Drop_Count, Avm_Address, Avm_Read, Avm_Write, Avm_WriteData
    );
    modport slave (
        output Read, R_Address, Write, W_Address, BitData, Avm_WaitRequest, Avm_ReadData, Avm_ReadDataValid,
        input Busy, ReadData, ReadValid, Timeout_Err, Drop_Count, Avm_Address, Avm_Read, Avm_Write, Avm_WriteData
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: sequences single-pixel read/write requests onto an Avalon-MM SDRAM port, reads first
module sdram_port_arbiter import fb_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic Clk,
    input logic Reset,
    sdram_port_arbiter_if.master bus
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    arb_state_t state, state_nxt;
    logic rd_pend, wr_pend, rd_done, rd_timeout;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [CNT_W-1:0] cnt;
    logic [8:0] drop_sum;

    always_comb begin
        rd_timeout = cnt == CNT_W'(TIMEOUT_CYCLES - 1);
        rd_done = state == RD_WAIT && (bus.Avm_ReadDataValid || rd_timeout);
        drop_sum = {1'b0, bus.Drop_Count} + {8'd0, bus.Read} + {8'd0, bus.Write};
        bus.Busy = state != IDLE || rd_pend || wr_pend;
        bus.Avm_Read = state == RD_ISSUE;
        bus.Avm_Write = state == WR_ISSUE;
        bus.Avm_Address = state == RD_ISSUE ? rd_addr : state == WR_ISSUE ? wr_addr : '0;
        bus.Avm_WriteData = state == WR_ISSUE ? wr_data : '0;
        state_nxt = state;
        case (state)
            IDLE:     state_nxt = rd_pend ? RD_ISSUE : wr_pend ? WR_ISSUE : IDLE;
            RD_ISSUE: state_nxt = bus.Avm_WaitRequest ? RD_ISSUE : RD_WAIT;
            RD_WAIT:  state_nxt = !rd_done ? RD_WAIT : wr_pend ? WR_ISSUE : IDLE;
            WR_ISSUE: state_nxt = bus.Avm_WaitRequest ? WR_ISSUE : rd_pend ? RD_ISSUE : IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else state <= state_nxt;
    end

    // Acceptance only happens in IDLE, so it never collides with the pend clears below
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rd_pend <= 1'b0;
            wr_pend <= 1'b0;
            rd_addr <= '0;
            wr_addr <= '0;
            wr_data <= '0;
            cnt <= '0;
            bus.ReadData <= '0;
            bus.ReadValid <= 1'b0;
            bus.Timeout_Err <= 1'b0;
            bus.Drop_Count <= '0;
        end else begin
            bus.ReadValid <= rd_done;
            cnt <= state == RD_WAIT ? cnt + 1'b1 : '0;
            if (!bus.Busy) begin
                if (bus.Read) begin
                    rd_pend <= 1'b1;
                    rd_addr <= bus.R_Address;
                end
                if (bus.Write) begin
                    wr_pend <= 1'b1;
                    wr_addr <= bus.W_Address;
                    wr_data <= bus.BitData;
                end
            end else begin
                bus.Drop_Count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
            end
            if (state == RD_ISSUE && !bus.Avm_WaitRequest) rd_pend <= 1'b0;
            if (state == WR_ISSUE && !bus.Avm_WaitRequest) wr_pend <= 1'b0;
            if (rd_done) begin
                bus.ReadData <= bus.Avm_ReadDataValid ? bus.Avm_ReadData : '0;
                bus.Timeout_Err <= bus.Timeout_Err | !bus.Avm_ReadDataValid;
            end
        end
    end
endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Downstream consumer of the frame-buffer address controller. Accepts single-pixel read and write requests (Read/Write pulses with R_Address/W_Address and 16-bit pixel data) and sequences them onto the Avalon-MM master port of the SDRAM controller.
- Generates the Busy signal the address controller uses to time its auto-increment.
- Reads have priority over writes, so display fetch is never starved.
- One transaction is outstanding at a time, with a read timeout for robustness.

Parameters:
- ADDR_W, 20, width of the pixel address {row[9:0], col[9:0]} passed unmodified to Avm_Address
- DATA_W, 16, pixel width
- TIMEOUT_CYCLES, 64, cycles allowed in RD_WAIT before a read is abandoned

Ports:
- Clk  in  1  system clock; all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- Read  in  1  read request, sampled each cycle
- R_Address  in  ADDR_W  read pixel address
- Write  in  1  write request, sampled each cycle
- W_Address  in  ADDR_W  write pixel address
- BitData  in  DATA_W  write pixel data, sampled with Write
- Busy  out  1  high while any request is pending or in flight
- ReadData  out  DATA_W  returned pixel
- ReadValid  out  1  one-cycle strobe qualifying ReadData
- Timeout_Err  out  1  sticky flag, set when a read times out
- Drop_Count  out  8  saturating count of requests ignored while Busy
- Avm_Address  out  ADDR_W  SDRAM address
- Avm_Read  out  1  SDRAM read strobe
- Avm_Write  out  1  SDRAM write strobe
- Avm_WriteData  out  DATA_W  SDRAM write data
- Avm_WaitRequest  in  1  SDRAM stall
- Avm_ReadData  in  DATA_W  SDRAM read data
- Avm_ReadDataValid  in  1  SDRAM read data qualifier

Behaviour:
- Reset (any cycle, including mid-transaction):
  - next edge clears state to IDLE and clears rd_pend/wr_pend.
  - Outputs go to 0: Busy, ReadData, ReadValid, Timeout_Err, Drop_Count, Avm_Read, Avm_Write, Avm_Address, Avm_WriteData.
  - Any in-flight SDRAM data arriving afterwards is ignored.
- Busy = (state != IDLE) | rd_pend | wr_pend. Busy is registered-state-derived and combinational from state/pend; it has no input paths.
- Acceptance:
  - A request is accepted only when sampled while Busy=0.
  - An accepted request latches its address (and BitData for writes) into the read or write holding register and sets its pend bit.
  - Read and Write together with Busy=0: both are accepted; the read runs first, then the write.
  - Any request sampled while Busy=1 is dropped and increments Drop_Count, saturating at 255. Read and Write dropped together count +2, saturating.
- States: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE.
  - IDLE: if rd_pend, go to RD_ISSUE; else if wr_pend, go to WR_ISSUE. Consequence: Avm_Read/Avm_Write first asserts 2 cycles after the request edge.
  - RD_ISSUE:
    - Avm_Read=1 with Avm_Address=read holding register, held stable while Avm_WaitRequest=1.
    - On an edge with WaitRequest=0: clear rd_pend and go to RD_WAIT. The timeout counter is loaded with 0.
  - RD_WAIT:
    - Avm_Read=0. The counter increments each cycle.
    - On Avm_ReadDataValid=1: register ReadData<=Avm_ReadData and pulse ReadValid in the following cycle.
    - If the counter reaches TIMEOUT_CYCLES-1 with no valid: ReadData<=0, pulse ReadValid, set Timeout_Err.
    - Either exit: go to WR_ISSUE if wr_pend, else IDLE.
  - WR_ISSUE:
    - Avm_Write=1 with address/data from the write holding register, held while WaitRequest=1.
    - On an edge with WaitRequest=0: clear wr_pend. Go to RD_ISSUE if rd_pend, else IDLE.
- Busy deasserts in the same cycle ReadValid pulses when no write is pending. For a lone write, Busy deasserts the cycle after the accepting WaitRequest=0 edge.
- Avm_ReadDataValid outside RD_WAIT is ignored.
- Avm_Read and Avm_Write are never high in the same cycle.
- No address range checking; wrap-around is owned by the address controller.

Decomposition:
- Shared package fb_pkg holds:
  - FB_COLS=640, FB_ROWS=480, FB_PIXELS=307200
  - ADDR_W/DATA_W defaults
  - arb_state_t enum {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE}
- No sub-module. The timeout counter and saturating drop counter stay inline; both are trivially small.

Test Plan:
- Read=1, R_Address=20'h00C05, WaitRequest=0, ReadDataValid two cycles after the strobe with data 16'hBEEF:
  - Avm_Read high 2 cycles after the request with Avm_Address=20'h00C05.
  - ReadValid pulses with ReadData=16'hBEEF; Busy falls the same cycle.
- Read and Write (W_Address=20'h00001, BitData=16'h1234) in the same cycle:
  - Avm_Read issues first.
  - After read data returns, Avm_Write issues with 20'h00001/16'h1234.
  - Busy stays high continuously until the write completes.
- Write with WaitRequest held 5 cycles:
  - Avm_Write, address and data stay stable for 6 cycles.
  - Busy drops the cycle after acceptance.
- Read with ReadDataValid never asserted:
  - ReadValid pulses with ReadData=0 after TIMEOUT_CYCLES in RD_WAIT.
  - Timeout_Err=1 and remains 1 until Reset.
- 300 Write pulses while Busy=1: Drop_Count saturates at 255 and no extra SDRAM cycles occur.
- Reset asserted in RD_WAIT, then late ReadDataValid:
  - Next edge: Busy=0, state IDLE.
  - No ReadValid pulse is produced.
